// File: rtl/fir_fold_sched_if.sv
`default_nettype none
// ============================================================================
// Module : fir_fold_sched_if
// Brief  : Sample/result valid-ready streams, coefficient config port and
//          busy status for the folded 6-tap FIR scheduler.
// Rev    : 1.0  initial release
// ============================================================================
interface fir_fold_sched_if #(
  parameter int DW = 16,
  parameter int CW = 3,
  parameter int OW = 19,
  parameter int AW = 3
);
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          coef_we;
  logic [AW-1:0] coef_addr;
  logic [CW-1:0] coef_wdata;
  logic          busy;

  // Scheduler side
  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, busy
  );

  // Producer / consumer / configuration side
  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, busy
  );
endinterface
`default_nettype wire

// File: rtl/fir_fold_sched.sv
`default_nettype none
// ============================================================================
// Module : fir_fold_sched
// Brief  : Folded 6-tap FIR. One multiplier and one accumulator are shared
//          across all taps, one tap per clock, with programmable coefficients.
// Rev    : 1.0  initial release
// ============================================================================
module fir_fold_sched #(
  parameter int TAPS = 6,
  parameter int DW   = 16,
  parameter int CW   = 3,
  parameter int OW   = 19,
  parameter int AW   = 3
) (
  input  wire logic        clk,
  input  wire logic        rst,   // asynchronous, active-low
  fir_fold_sched_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);
  localparam logic [AW-1:0] NUM_TAPS = AW'(TAPS);

  // Coefficient values restored by reset
  function automatic logic [CW-1:0] coef_init(input int k);
    case (k)
      0, 1:    return CW'(3);
      2, 3:    return CW'(2);
      default: return CW'(1);
    endcase
  endfunction

  state_t        state;
  logic [AW-1:0] idx;
  logic [OW-1:0] acc;
  logic [DW-1:0] hist [TAPS];
  logic [CW-1:0] coef [TAPS];
  logic          res_valid;
  logic [OW-1:0] res_data;

  logic [OW-1:0] product;
  logic [OW-1:0] sum;

  // Shared multiply-accumulate datapath for the currently selected tap
  always_comb begin
    product = OW'(hist[idx]) * OW'(coef[idx]);
    sum     = acc + product;   // wraps modulo 2^OW by construction
  end

  // Scheduler FSM: accept sample, run one tap per clock, hold result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      idx       <= '0;
      acc       <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      for (int k = 0; k < TAPS; k++) begin
        hist[k] <= '0;
        coef[k] <= coef_init(k);
      end
    end else begin
      // Config writes land on the same edge as a sample accept, so the new
      // coefficient is already in place for that sample's first tap.
      if (state == IDLE && bus.coef_we && bus.coef_addr < NUM_TAPS) begin
        coef[bus.coef_addr] <= bus.coef_wdata;
      end

      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            hist[0] <= bus.in_data;
            for (int k = 1; k < TAPS; k++) begin
              hist[k] <= hist[k-1];
            end
            acc   <= '0;
            idx   <= '0;
            state <= MAC;
          end
        end
        MAC: begin
          if (idx == LAST_TAP) begin
            res_data  <= sum;
            res_valid <= 1'b1;
            idx       <= '0;
            state     <= HOLD;
          end else begin
            acc <= sum;
            idx <= idx + AW'(1);
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // in_ready is gated by reset so it stays low while reset is held
  assign bus.in_ready  = rst && (state == IDLE);
  assign bus.out_valid = res_valid;
  assign bus.out_data  = res_data;
  assign bus.busy      = (state == MAC) || (state == HOLD);

endmodule
`default_nettype wire

// File: tb/tb_fir_fold_sched.sv
`default_nettype none
// ============================================================================
// Module : tb_fir_fold_sched
// Brief  : Self-checking bench for fir_fold_sched: directed vector table,
//          reset corner cases and randomized traffic against a sum model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fir_fold_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  fir_fold_sched_if bus ();

  fir_fold_sched u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] d;
    bit          we;
    logic [2:0]  a;
    logic [2:0]  wd;
    int          hold;
    bit          hold_we;
    logic [18:0] exp;
  } vec_t;

  vec_t vecs[$];

  int nvec = 0;
  int nerr = 0;

  // Reference model state: sample history and coefficients
  int unsigned mh [6];
  int unsigned mc [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic [15:0] d, input bit we, input logic [2:0] a,
                     input logic [2:0] wd, input int hold, input bit hwe,
                     input logic [18:0] exp);
    vec_t v;
    v.d = d; v.we = we; v.a = a; v.wd = wd; v.hold = hold; v.hold_we = hwe; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 6; k++) begin
      mh[k] = 0;
      mc[k] = (k < 2) ? 3 : (k < 4) ? 2 : 1;
    end
  endtask

  // y = sum coef[k]*x[n-k], wrapped to 19 bits
  task automatic model_step(input logic [15:0] d, input bit we, input logic [2:0] a,
                            input logic [2:0] wd, output logic [18:0] y);
    longint unsigned s;
    if (we && a < 6) mc[a] = wd;
    for (int k = 5; k > 0; k--) mh[k] = mh[k-1];
    mh[0] = d;
    s = 0;
    for (int k = 0; k < 6; k++) s += longint'(mh[k]) * longint'(mc[k]);
    y = 19'(s % (64'd1 << 19));
  endtask

  // One full transaction: accept, MAC, optional backpressure, output handshake
  task automatic send(input logic [15:0] d, input bit we, input logic [2:0] a,
                      input logic [2:0] wd, input int hold, input bit hwe,
                      output logic [18:0] got);
    int  n;
    int  lat;
    bit  seen;
    @(negedge clk);
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid   = 1'b1;
    bus.in_data    = d;
    bus.coef_we    = we;
    bus.coef_addr  = a;
    bus.coef_wdata = wd;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    bus.in_data  = 16'($urandom);   // must not matter after the accept edge
    seen = 0;
    lat  = 0;
    for (int i = 1; i <= 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        seen = 1;
        lat  = i;
      end else if (i == 3) begin
        check("mac_busy", 32'(bus.busy), 32'd1);
        check("mac_in_ready", 32'(bus.in_ready), 32'd0);
      end
    end
    check("latency", 32'(lat), 32'd6);
    got = bus.out_data;
    for (int h = 0; h < hold; h++) begin
      bus.coef_we    = hwe;
      bus.coef_addr  = 3'($urandom_range(0, 7));
      bus.coef_wdata = 3'($urandom);
      bus.in_valid   = 1'b1;
      @(posedge clk);
      #1;
      bus.coef_we  = 1'b0;
      bus.in_valid = 1'b0;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_data", 32'(bus.out_data), 32'(got));
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      check("hold_busy", 32'(bus.busy), 32'd1);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("post_valid", 32'(bus.out_valid), 32'd0);
    check("post_in_ready", 32'(bus.in_ready), 32'd1);
    check("post_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [18:0] got;
    logic [18:0] exp;
    logic [15:0] d;
    bit          we;
    logic [2:0]  a;
    logic [2:0]  wd;

    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus.coef_we    = 1'b0;
    bus.coef_addr  = '0;
    bus.coef_wdata = '0;

    // Impulse
    add(16'd1, 0, 0, 0, 0, 0, 19'd3);
    add(16'd0, 0, 0, 0, 0, 0, 19'd3);
    add(16'd0, 0, 0, 0, 0, 0, 19'd2);
    add(16'd0, 0, 0, 0, 0, 0, 19'd2);
    add(16'd0, 0, 0, 0, 0, 0, 19'd1);
    add(16'd0, 0, 0, 0, 0, 0, 19'd1);
    add(16'd0, 0, 0, 0, 0, 0, 19'd0);
    // Step of 100, with backpressure and an ignored HOLD-time coef write
    add(16'd100, 0, 0, 0, 0, 0, 19'd300);
    add(16'd100, 0, 0, 0, 5, 1, 19'd600);
    add(16'd100, 0, 0, 0, 0, 0, 19'd800);
    add(16'd100, 0, 0, 0, 2, 1, 19'd1000);
    add(16'd100, 0, 0, 0, 0, 0, 19'd1100);
    add(16'd100, 0, 0, 0, 0, 0, 19'd1200);
    // Flush the step history
    add(16'd0, 0, 0, 0, 0, 0, 19'd900);
    add(16'd0, 0, 0, 0, 0, 0, 19'd600);
    add(16'd0, 0, 0, 0, 0, 0, 19'd400);
    add(16'd0, 0, 0, 0, 0, 0, 19'd200);
    add(16'd0, 0, 0, 0, 0, 0, 19'd100);
    add(16'd0, 0, 0, 0, 0, 0, 19'd0);
    // Full-scale input, accumulator wraps at 2^19
    add(16'hFFFF, 0, 0, 0, 0, 0, 19'd196605);
    add(16'hFFFF, 0, 0, 0, 0, 0, 19'd393210);
    add(16'hFFFF, 0, 0, 0, 0, 0, 19'd524280);
    add(16'hFFFF, 0, 0, 0, 0, 0, 19'd131062);
    add(16'hFFFF, 0, 0, 0, 0, 0, 19'd196597);
    add(16'hFFFF, 0, 0, 0, 0, 0, 19'd262132);
    // Flush the full-scale history
    add(16'd0, 0, 0, 0, 0, 0, 19'd65527);
    add(16'd0, 0, 0, 0, 0, 0, 19'd393210);
    add(16'd0, 0, 0, 0, 0, 0, 19'd262140);
    add(16'd0, 0, 0, 0, 0, 0, 19'd131070);
    add(16'd0, 0, 0, 0, 0, 0, 19'd65535);
    add(16'd0, 0, 0, 0, 0, 0, 19'd0);
    // coef[0]=7 on the accept edge, then an out-of-range address write
    add(16'd1, 1, 3'd0, 3'd7, 0, 0, 19'd7);
    add(16'd0, 1, 3'd6, 3'd5, 0, 0, 19'd3);
    add(16'd0, 1, 3'd7, 3'd0, 0, 0, 19'd2);
    add(16'd0, 0, 0, 0, 0, 0, 19'd2);
    add(16'd0, 0, 0, 0, 0, 0, 19'd1);
    add(16'd0, 0, 0, 0, 0, 0, 19'd1);
    add(16'd1, 0, 0, 0, 0, 0, 19'd7);

    // Reset state
    #12;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) begin
      send(vecs[i].d, vecs[i].we, vecs[i].a, vecs[i].wd, vecs[i].hold, vecs[i].hold_we, got);
      check($sformatf("vec%0d", i), 32'(got), 32'(vecs[i].exp));
    end

    // Reset in the middle of MAC (tap 3)
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd5000;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("midmac_out_valid", 32'(bus.out_valid), 32'd0);
    check("midmac_busy", 32'(bus.busy), 32'd0);
    check("midmac_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      send((i == 0) ? 16'd1 : 16'd0, 0, 0, 0, 0, 0, got);
      exp = (i < 2) ? 19'd3 : (i < 4) ? 19'd2 : 19'd1;
      check($sformatf("after_rst_imp%0d", i), 32'(got), 32'(exp));
    end

    // Reset while a result is held: out_valid must drop without a clock edge
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd777;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("hold_pre_rst_valid", 32'(bus.out_valid), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("hold_rst_valid", 32'(bus.out_valid), 32'd0);
    check("hold_rst_data", 32'(bus.out_data), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Randomized traffic against the reference model
    model_reset();
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0:       d = 16'd0;
        1:       d = 16'hFFFF;
        default: d = 16'($urandom);
      endcase
      we = ($urandom_range(0, 3) == 0);
      a  = 3'($urandom_range(0, 7));
      wd = 3'($urandom);
      model_step(d, we, a, wd, exp);
      send(d, we, a, wd, $urandom_range(0, 3), 1'($urandom), got);
      check($sformatf("rand%0d", i), 32'(got), 32'(exp));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
